// File: rtl/load_data_ext_if.sv
// rtl/load_data_ext_if.sv - load formatter handshake bundle: memory read side and writeback side
interface load_data_ext_if #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5
);
    localparam int OFF_W = $clog2(DATA_W / 8);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_rdata;
    logic [OFF_W-1:0]  in_off;
    logic [1:0]        in_size;
    logic              in_unsign;
    logic [TAG_W-1:0]  in_tag;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [TAG_W-1:0]  out_tag;
    logic              out_err;

    modport master (
        output in_valid, in_rdata, in_off, in_size, in_unsign, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_err
    );

    modport slave (
        input  in_valid, in_rdata, in_off, in_size, in_unsign, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_err
    );
endinterface

// File: rtl/load_data_ext.sv
// rtl/load_data_ext.sv - load lane select, sign/zero extend, misalign flag, one-deep output register
module load_data_ext #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8,
    parameter int TAG_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    load_data_ext_if.slave   bus,
    output logic [CNT_W-1:0] err_cnt,
    input  logic             cnt_clr
);
    localparam int OFF_W = $clog2(DATA_W / 8);
    localparam logic [6:0] DW7 = 7'(DATA_W);

    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] low_mask;
    logic [DATA_W-1:0] top_bit;
    logic [DATA_W-1:0] fmt_data;
    logic [6:0]        fw;
    logic [OFF_W-1:0]  size_mask;
    logic              ext;
    logic              fmt_err;
    logic              accept;

    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic [TAG_W-1:0]  tag_q;
    logic              err_q;
    logic [CNT_W-1:0]  cnt_q;

    // The field's sign bit is located through the mask itself, so a
    // full-width field has no upper bits to fill and passes through untouched.
    always_comb begin
        shifted   = bus.in_rdata >> {bus.in_off, 3'b000};
        fw        = 7'd8 << bus.in_size;
        size_mask = OFF_W'((4'd1 << bus.in_size) - 4'd1);
        fmt_err   = (fw > DW7) || ((bus.in_off & size_mask) != '0);
        low_mask  = {DATA_W{1'b1}} >> (DW7 - fw);
        top_bit   = low_mask & ~(low_mask >> 1);
        ext       = !bus.in_unsign && (|(shifted & top_bit));
        fmt_data  = '0;
        if (!fmt_err) begin
            fmt_data = (shifted & low_mask) | ({DATA_W{ext}} & ~low_mask);
        end
    end

    assign bus.in_ready  = !valid_q || bus.out_ready;
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.out_tag   = tag_q;
    assign bus.out_err   = err_q;
    assign err_cnt       = cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            tag_q   <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            valid_q <= 1'b1;
            data_q  <= fmt_data;
            tag_q   <= bus.in_tag;
            err_q   <= fmt_err;
        end else if (bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    // Errors are counted when the beat enters, not when it leaves.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            cnt_q <= '0;
        end else if (accept && fmt_err && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
endmodule
